pipelined_cla_adder: RTL

// Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// The WIDTH-bit operation is split into NB = WIDTH/BLOCK_W lookahead blocks.
// One pipeline stage resolves one block, so the block carry ripples through the registers.

---
 rtl/pipelined_cla_adder_if.sv | 27 ++
 rtl/pipelined_cla_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// Input channel carries operands and the add/sub select; output channel carries result and flags.
// The adder is the slave and the producer/consumer side is the master.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK_W-bit lookahead block per stage.
// Latency NB = WIDTH/BLOCK_W cycles from accept edge to out_valid; one beat per cycle.
// A stalled output (out_valid & !out_ready) freezes every stage and drops in_ready.
module pipelined_cla_adder #(
    parameter int WIDTH   = 32,
    parameter int BLOCK_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    pipelined_cla_adder_if.slave    bus
);
    // WIDTH must be a whole multiple of BLOCK_W.
    localparam int NB = WIDTH / BLOCK_W;

    // Stage-k inputs: operand words, already-resolved lower sum bits, block carry-in, valid.
    logic [WIDTH-1:0] a_s   [NB];
    logic [WIDTH-1:0] b_s   [NB];
    logic [WIDTH-1:0] sum_s [NB];
    logic             c_s   [NB];
    logic             vld_s [NB];

    // Final-stage (output) registers.
    logic             out_vld_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;

    // Single global advance enable: whole pipe moves unless the output is held.
    logic en;
    assign en           = !out_vld_q | bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = out_vld_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the block-0 carry-in.
    assign a_s[0]   = bus.in_a;
    assign b_s[0]   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c_s[0]   = bus.in_sub;
    assign sum_s[0] = '0;
    assign vld_s[0] = bus.in_valid;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        localparam int LO = k * BLOCK_W;

        logic [BLOCK_W-1:0] blk_a;
        logic [BLOCK_W-1:0] blk_b;
        logic [BLOCK_W-1:0] blk_g;
        logic [BLOCK_W-1:0] blk_p;
        logic [BLOCK_W-1:0] blk_sum;
        logic [BLOCK_W:0]   cv;
        logic               grp_g;
        logic               grp_p;
        logic [WIDTH-1:0]   sum_d;

        // Block lookahead: carry into bit i+1 = G[i:0] | P[i:0] & cin, with g=a&b, p=a|b.
        always_comb begin
            blk_a = a_s[k][LO +: BLOCK_W];
            blk_b = b_s[k][LO +: BLOCK_W];
            blk_g = blk_a & blk_b;
            blk_p = blk_a | blk_b;
            grp_g = 1'b0;
            grp_p = 1'b1;
            cv    = '0;
            cv[0] = c_s[k];
            for (int i = 0; i < BLOCK_W; i++) begin
                grp_g     = blk_g[i] | (blk_p[i] & grp_g);
                grp_p     = grp_p & blk_p[i];
                cv[i + 1] = grp_g | (grp_p & c_s[k]);
            end
            blk_sum           = blk_a ^ blk_b ^ cv[BLOCK_W-1:0];
            sum_d             = sum_s[k];
            sum_d[LO +: BLOCK_W] = blk_sum;
        end

        if (k < NB - 1) begin : g_mid
            logic             vld_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] sum_q;
            logic             c_q;

            // Intermediate stage register; data only loads for real beats so bubbles leave it untouched.
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                end else if (en) begin
                    vld_q <= vld_s[k];
                    if (vld_s[k]) begin
                        a_q   <= a_s[k];
                        b_q   <= b_s[k];
                        sum_q <= sum_d;
                        c_q   <= cv[BLOCK_W];
                    end
                end
            end

            assign a_s[k + 1]   = a_q;
            assign b_s[k + 1]   = b_q;
            assign sum_s[k + 1] = sum_d_fwd(sum_q);
            assign c_s[k + 1]   = c_q;
            assign vld_s[k + 1] = vld_q;
        end else begin : g_last
            // Output register; result and flags hold their last value across bubbles and stalls.
            always_ff @(posedge clock) begin
                if (reset) begin
                    out_vld_q  <= 1'b0;
                    out_sum_q  <= '0;
                    out_cout_q <= 1'b0;
                    out_ovf_q  <= 1'b0;
                end else if (en) begin
                    out_vld_q <= vld_s[k];
                    if (vld_s[k]) begin
                        out_sum_q  <= sum_d;
                        out_cout_q <= cv[BLOCK_W];
                        out_ovf_q  <= cv[BLOCK_W] ^ cv[BLOCK_W-1];
                    end
                end
            end
        end
    end

    // Lower sum bits pass through the pipe unchanged.
    function automatic logic [WIDTH-1:0] sum_d_fwd(input logic [WIDTH-1:0] s);
        return s;
    endfunction

endmodule
